// File: rtl/srcnn_output_formatter.sv
// srcnn_output_formatter
// Converts the SRCNN core's 3-channel signed result stream into 8-bit RGB
// (round, shift, saturate) and adds AXI4-Stream video framing.
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   slave_valid_i/ready_o/data_i input pixel stream, channel c at [c*AW +: AW]
//   master_tvalid_o/tready_i     output handshake
//   master_tdata_o               {B, G, R}, 8 bits each
//   master_tuser_o               start of frame (row 0, col 0)
//   master_tlast_o               end of line (col Width-1)
//   frame_done_o                 pulse after the last pixel of a frame leaves
module srcnn_output_formatter #(
  parameter int unsigned Height          = 600,
  parameter int unsigned Width           = 800,
  parameter int unsigned ActivationWidth = 10,
  parameter int unsigned RightShift      = 0
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         slave_valid_i,
  output logic                         slave_ready_o,
  input  logic [3*ActivationWidth-1:0] slave_data_i,
  output logic                         master_tvalid_o,
  input  logic                         master_tready_i,
  output logic [23:0]                  master_tdata_o,
  output logic                         master_tuser_o,
  output logic                         master_tlast_o,
  output logic                         frame_done_o
);

  localparam int unsigned ExtW      = ActivationWidth + 1;
  // Half an output LSB; zero when no fractional bits are dropped.
  localparam int unsigned RoundBias = (32'd1 << RightShift) >> 1;
  localparam int unsigned ColW      = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned RowW      = (Height > 1) ? $clog2(Height) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } pixel_t;

  // Round-half-up, arithmetic shift, clamp to 0..255.
  function automatic logic [7:0] format_channel(input logic [ActivationWidth-1:0] raw);
    logic signed [ExtW-1:0] sum;
    logic signed [31:0]     t;
    logic [7:0]             res;
    sum = ExtW'($signed(raw)) + $signed(ExtW'(RoundBias));
    t   = 32'(sum >>> RightShift);
    if (t < 32'sd0) begin
      res = 8'd0;
    end else if (t > 32'sd255) begin
      res = 8'hff;
    end else begin
      res = t[7:0];
    end
    return res;
  endfunction

  pixel_t          head_q, skid_q, in_pix_c;
  logic [1:0]      count_q, count_next_c;
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic            in_fire_c, out_fire_c;

  assign in_fire_c  = slave_valid_i & slave_ready_o;
  assign out_fire_c = master_tvalid_o & master_tready_i;

  assign master_tdata_o = head_q.data;
  assign master_tuser_o = head_q.sof;
  assign master_tlast_o = head_q.eol;

  // Format the incoming pixel and tag it with its framing position.
  always_comb begin
    in_pix_c = '0;
    for (int c = 0; c < 3; c++) begin
      in_pix_c.data[8*c +: 8] = format_channel(slave_data_i[c*ActivationWidth +: ActivationWidth]);
    end
    in_pix_c.sof = (row_q == '0) && (col_q == '0);
    in_pix_c.eol = (col_q == LastCol);
    in_pix_c.eof = (col_q == LastCol) && (row_q == LastRow);
  end

  // Buffer occupancy after this cycle's handshakes.
  always_comb begin
    count_next_c = count_q;
    if (in_fire_c && !out_fire_c) begin
      count_next_c = count_q + 2'd1;
    end else if (out_fire_c && !in_fire_c) begin
      count_next_c = count_q - 2'd1;
    end
  end

  // Two-entry buffer: head_q drives the master port, skid_q holds the second pixel.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q          <= '0;
      skid_q          <= '0;
      count_q         <= 2'd0;
      col_q           <= '0;
      row_q           <= '0;
      master_tvalid_o <= 1'b0;
      slave_ready_o   <= 1'b0;
      frame_done_o    <= 1'b0;
    end else begin
      frame_done_o <= out_fire_c & head_q.eof;

      if (in_fire_c) begin
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= (row_q == LastRow) ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end

      case (count_q)
        2'd0: begin
          if (in_fire_c) head_q <= in_pix_c;
        end
        2'd1: begin
          if (in_fire_c && out_fire_c) begin
            head_q <= in_pix_c;
          end else if (in_fire_c) begin
            skid_q <= in_pix_c;
          end
        end
        default: begin
          if (out_fire_c) head_q <= skid_q;
        end
      endcase

      count_q         <= count_next_c;
      master_tvalid_o <= (count_next_c != 2'd0);
      slave_ready_o   <= (count_next_c != 2'd2);
    end
  end

endmodule

// File: tb/tb_srcnn_output_formatter.sv
// Bench for srcnn_output_formatter: two instances (4x5 RS=0 and 2x3 RS=2)
// share stimulus; sel chooses which instance's outputs are examined.
module tb_srcnn_output_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        tready;
  logic        sel;
  logic [29:0] data;

  logic        a_ready, a_tvalid, a_tuser, a_tlast, a_fd;
  logic [23:0] a_tdata;
  logic        b_ready, b_tvalid, b_tuser, b_tlast, b_fd;
  logic [23:0] b_tdata;

  logic        m_ready, m_tvalid, m_tuser, m_tlast, m_fd;
  logic [23:0] m_tdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srcnn_output_formatter #(.Height(4), .Width(5), .ActivationWidth(10), .RightShift(0)) dut_a (
    .clock_i(clk), .reset_i(rst), .slave_valid_i(valid), .slave_ready_o(a_ready),
    .slave_data_i(data), .master_tvalid_o(a_tvalid), .master_tready_i(tready),
    .master_tdata_o(a_tdata), .master_tuser_o(a_tuser), .master_tlast_o(a_tlast),
    .frame_done_o(a_fd)
  );

  srcnn_output_formatter #(.Height(2), .Width(3), .ActivationWidth(10), .RightShift(2)) dut_b (
    .clock_i(clk), .reset_i(rst), .slave_valid_i(valid), .slave_ready_o(b_ready),
    .slave_data_i(data), .master_tvalid_o(b_tvalid), .master_tready_i(tready),
    .master_tdata_o(b_tdata), .master_tuser_o(b_tuser), .master_tlast_o(b_tlast),
    .frame_done_o(b_fd)
  );

  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_tvalid = sel ? b_tvalid : a_tvalid;
  assign m_tuser  = sel ? b_tuser  : a_tuser;
  assign m_tlast  = sel ? b_tlast  : a_tlast;
  assign m_fd     = sel ? b_fd     : a_fd;
  assign m_tdata  = sel ? b_tdata  : a_tdata;

  typedef struct {
    bit          sel;
    int          r;
    int          g;
    int          b;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int cfg_h();
    return sel ? 2 : 4;
  endfunction
  function automatic int cfg_w();
    return sel ? 3 : 5;
  endfunction
  function automatic int cfg_rs();
    return sel ? 2 : 0;
  endfunction

  // Divide by 2^rs rounding half up (floor of (v + half) / 2^rs), then clamp.
  function automatic logic [7:0] ref_chan(input int v, input int rs);
    int d, num, q;
    if (rs == 0) begin
      q = v;
    end else begin
      d   = 1 << rs;
      num = v + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  // Expected {tuser, tlast, tdata} for the idx-th pixel since reset.
  function automatic logic [25:0] ref_out(input int idx, input logic [29:0] d);
    logic [23:0] px;
    logic [9:0]  raw;
    logic        u, l;
    for (int c = 0; c < 3; c++) begin
      raw = d[c*10 +: 10];
      px[8*c +: 8] = ref_chan(int'($signed(raw)), cfg_rs());
    end
    u = (idx % (cfg_h() * cfg_w())) == 0;
    l = (idx % cfg_w()) == cfg_w() - 1;
    return {u, l, px};
  endfunction

  task automatic do_reset(input bit check_zero);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; tready = 1'b0;
    @(negedge clk);
    if (check_zero) begin
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata", 32'(m_tdata), 32'd0);
      check("rst_tuser", 32'(m_tuser), 32'd0);
      check("rst_tlast", 32'(m_tlast), 32'd0);
      check("rst_frame_done", 32'(m_fd), 32'd0);
      check("rst_ready", 32'(m_ready), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Randomised stream against a queue scoreboard; also checks AXI hold and frame_done.
  task automatic run_stream(input int n, input int vpct, input int rpct,
                            output int cycles, output int fd_count);
    logic [25:0] exp_q[$];
    logic [25:0] e, prev_out, cur_out;
    int          pushed, popped;
    bit          prev_hold, fd_exp, in_fire, out_fire;
    int          frame;
    pushed = 0; popped = 0; prev_hold = 0; fd_exp = 0;
    cycles = 0; fd_count = 0; prev_out = '0;
    frame = cfg_h() * cfg_w();
    while ((pushed < n || exp_q.size() != 0) && cycles < 2000) begin
      @(negedge clk);
      cur_out = {m_tuser, m_tlast, m_tdata};
      check("frame_done", 32'(m_fd), 32'(fd_exp));
      if (m_fd) fd_count++;
      if (prev_hold) begin
        check("tvalid_retracted", 32'(m_tvalid), 32'd1);
        check("held_payload", 32'(cur_out), 32'(prev_out));
      end
      valid  = (pushed < n) && ($urandom_range(99) < vpct);
      data   = 30'($urandom);
      tready = ($urandom_range(99) < rpct);
      in_fire  = valid && m_ready;
      out_fire = m_tvalid && tready;
      fd_exp   = 0;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(cur_out), 32'h3ffffff);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'(cur_out), 32'(e));
          fd_exp = (popped % frame) == frame - 1;
          popped++;
        end
      end
      prev_hold = m_tvalid && !tready;
      prev_out  = cur_out;
      if (in_fire) begin
        exp_q.push_back(ref_out(pushed, data));
        pushed++;
      end
      cycles++;
    end
    check("stream_drained", 32'(exp_q.size() + (n - pushed)), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    check("frame_done_last", 32'(m_fd), 32'(fd_exp));
    if (m_fd) fd_count++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [29:0] d0, d1, d2;
    int          cyc, fd;

    rst = 1'b1; valid = 1'b0; tready = 1'b0; sel = 1'b0; data = '0;

    tbl[0] = '{0, -5, 300, 128, 24'h80FF00};
    tbl[1] = '{0, 0, 255, 256, 24'hFFFF00};
    tbl[2] = '{0, -512, 511, 1, 24'h01FF00};
    tbl[3] = '{0, 7, 100, 200, 24'hC86407};
    tbl[4] = '{1, 9, 10, -2, 24'h000302};
    tbl[5] = '{1, -3, 511, -512, 24'h008000};
    tbl[6] = '{1, 6, 1, 2, 24'h010002};
    tbl[7] = '{1, 5, -1, -6, 24'h000001};

    do_reset(1'b1);

    // Arithmetic vectors: one pixel each, visible one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      do_reset(1'b0);
      check("vec_ready", 32'(m_ready), 32'd1);
      valid = 1'b1;
      data  = {10'(tbl[i].b), 10'(tbl[i].g), 10'(tbl[i].r)};
      @(negedge clk);
      valid = 1'b0;
      check("vec_latency", 32'(m_tvalid), 32'd1);
      check("vec_tdata", 32'(m_tdata), 32'(tbl[i].exp));
      tready = 1'b1;
      @(negedge clk);
      tready = 1'b0;
      check("vec_empty", 32'(m_tvalid), 32'd0);
    end

    // Framing on 2x3, full rate: 7 pixels, no bubbles, one frame_done.
    sel = 1'b1;
    do_reset(1'b0);
    run_stream(7, 100, 100, cyc, fd);
    check("framing_cycles", 32'(cyc), 32'd8);
    check("framing_frame_done_count", 32'(fd), 32'd1);

    // Backpressure on 2x3: two accepted, held, then released in order.
    do_reset(1'b0);
    d0 = 30'($urandom); d1 = 30'($urandom); d2 = 30'($urandom);
    tready = 1'b0; valid = 1'b1; data = d0;
    @(negedge clk);
    check("bp_ready_one", 32'(m_ready), 32'd1);
    check("bp_first", 32'({m_tuser, m_tlast, m_tdata}), 32'(ref_out(0, d0)));
    data = d1;
    @(negedge clk);
    check("bp_ready_full", 32'(m_ready), 32'd0);
    data = d2;
    @(negedge clk);
    check("bp_ready_still_full", 32'(m_ready), 32'd0);
    check("bp_tvalid_held", 32'(m_tvalid), 32'd1);
    check("bp_data_held", 32'({m_tuser, m_tlast, m_tdata}), 32'(ref_out(0, d0)));
    tready = 1'b1;
    @(negedge clk);
    check("bp_second", 32'({m_tuser, m_tlast, m_tdata}), 32'(ref_out(1, d1)));
    check("bp_ready_back", 32'(m_ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    check("bp_third", 32'({m_tuser, m_tlast, m_tdata}), 32'(ref_out(2, d2)));
    @(negedge clk);
    tready = 1'b0;
    check("bp_drained", 32'(m_tvalid), 32'd0);

    // Random valid/ready over three frames on each instance.
    sel = 1'b0;
    do_reset(1'b0);
    run_stream(60, 50, 50, cyc, fd);
    check("rand_a_frames", 32'(fd), 32'd3);
    sel = 1'b1;
    do_reset(1'b0);
    run_stream(18, 50, 50, cyc, fd);
    check("rand_b_frames", 32'(fd), 32'd3);

    // Mid-row reset on 4x5 with the buffer full.
    sel = 1'b0;
    do_reset(1'b0);
    run_stream(7, 100, 100, cyc, fd);
    tready = 1'b0; valid = 1'b1; data = 30'($urandom);
    @(negedge clk);
    data = 30'($urandom);
    @(negedge clk);
    valid = 1'b0;
    check("mid_full_ready", 32'(m_ready), 32'd0);
    check("mid_full_tvalid", 32'(m_tvalid), 32'd1);
    do_reset(1'b1);
    check("mid_ready_after", 32'(m_ready), 32'd1);
    d0 = 30'($urandom);
    valid = 1'b1; data = d0;
    @(negedge clk);
    valid = 1'b0;
    check("mid_tvalid_after", 32'(m_tvalid), 32'd1);
    check("mid_first_pixel", 32'({m_tuser, m_tlast, m_tdata}), 32'(ref_out(0, d0)));
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    check("mid_drained", 32'(m_tvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srcnn_output_formatter.md
Name: srcnn_output_formatter

Overview:
- Sits directly downstream of the SRCNN core's final convolution output FIFO.
- Converts the 3-channel signed ActivationWidth-bit result stream into 8-bit-per-channel RGB, applying round, shift and saturate.
- Attaches AXI4-Stream video framing (tuser = start of frame, tlast = end of line) from row/column counters.
- Contains a 2-entry output buffer, so it sustains one pixel per clock and never makes slave_ready_o depend combinationally on master_tready_i.

Parameters:
- Height, 600, frame height in pixels.
- Width, 800, frame width in pixels.
- ActivationWidth, 10, bits per input channel, two's complement.
- RightShift, 0, fractional bits dropped before clamping; 0..ActivationWidth-1.

Ports:
- clock_i  in  1  system clock, all logic on rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- slave_valid_i  in  1  input pixel valid.
- slave_ready_o  out  1  input pixel accepted when valid and ready are both high.
- slave_data_i  in  3*ActivationWidth  channel c at [c*ActivationWidth +: ActivationWidth]; c=0 R, 1 G, 2 B.
- master_tvalid_o  out  1  output pixel valid.
- master_tready_i  in  1  downstream ready.
- master_tdata_o  out  24  channel c at [8*c +: 8].
- master_tuser_o  out  1  high on pixel (row 0, col 0).
- master_tlast_o  out  1  high on col Width-1 of every row.
- frame_done_o  out  1  one-cycle pulse when the pixel (Height-1, Width-1) completes its output handshake.

Behaviour:
- Reset (synchronous, active-high; clock_i, reset_i): buffer emptied; row=0, col=0.
  - Reset values: master_tvalid_o=0, master_tdata_o=0, master_tuser_o=0, master_tlast_o=0, frame_done_o=0, slave_ready_o=0.
  - slave_ready_o rises the first cycle after reset deasserts.
- Reset mid-frame discards buffered pixels, and the next accepted pixel is (0,0).
- Per-channel arithmetic:
  - v = signed input.
  - If RightShift>0: t = (v + 2^(RightShift-1)) >>> RightShift, computed at ActivationWidth+1 bits so no overflow; else t = v.
  - out = 0 if t<0; 255 if t>255; else t[7:0].
  - Channels are independent.
- Framing:
  - tuser/tlast are computed from (row,col) at acceptance and stored with the pixel.
  - col increments on every accepted input. At Width-1, col wraps to 0 and row increments. At (Height-1, Width-1), both wrap to 0.
- Buffer: 2 entries, FIFO order.
  - slave_ready_o = (count<2), driven from registered state only.
  - Accepted pixel is visible on the master port the next cycle: latency 1 when empty.
  - Simultaneous input and output handshake: count unchanged, order preserved.
  - Full (count=2) with master_tready_i=0: slave_ready_o=0 and outputs held stable.
- AXI rules:
  - Once master_tvalid_o=1, master_tdata_o/tuser/tlast must not change until the handshake completes.
  - master_tvalid_o never depends on master_tready_i.
- frame_done_o asserts the cycle after the output handshake of the pixel carrying tlast on the last row.
- Throughput: with master_tready_i held 1 and slave_valid_i held 1, one pixel per clock indefinitely, with no bubbles.

Test Plan:
- Saturation, RightShift=0: inputs R=-5, G=300, B=128 -> tdata={B=128, G=255, R=0} = 0x80FF00, 1 cycle after accept.
- Rounding, RightShift=2: R=9 (2.25), G=10 (2.5), B=-2 -> R=2, G=3, B=0 (−2+2=0 >>>2=0).
- Framing, Height=2, Width=3, continuous stream of 6 pixels:
  - tuser only on pixel 0.
  - tlast on pixels 2 and 5.
  - frame_done_o pulses once, 1 cycle after pixel 5 transfers.
  - pixel 6 carries tuser again.
- Backpressure: hold master_tready_i=0 while feeding 3 pixels -> exactly 2 accepted, slave_ready_o=0, tdata stable. Release -> all 3 pixels emerge in order with correct tlast.
- Random valid/ready toggling (50% each) over 3 frames of 4x5 -> output sequence equals the scoreboard model; no drops or duplicates; tvalid never retracted without a handshake.
- Reset asserted mid-row (after 7 pixels of a 4x5 frame) with 2 entries buffered -> all outputs 0 next cycle; after release, first accepted pixel carries tuser=1.
